// File: rtl/weight_memory_bank.sv
// Multi-channel weight store for one ELM layer: run-time word writes, then a
// start-triggered parallel stream of NUM_WEIGHTS words per channel with valid/ready.
module weight_memory_bank #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_WEIGHTS = 784,
  parameter int CH_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wen,
  input  logic [CH_WIDTH-1:0]          wch,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic                         wr_drop,
  input  logic                         start,
  output logic                         busy,
  input  logic                         rd_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] wout,
  output logic                         wout_valid,
  output logic                         wout_last
);

  // state | meaning
  // IDLE  | writes accepted, waiting for start
  // RUN   | issuing one read per cycle the output register can take
  // DRAIN | last word issued, waiting for its acceptance
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int                    DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);
  localparam logic [CH_WIDTH:0]     NUM_CH_W  = (CH_WIDTH+1)'(NUM_CH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];

  state_t                       state_q;
  logic [ADDR_WIDTH-1:0]        cnt_q;
  logic                         busy_q;
  logic                         wr_drop_q;
  logic                         wout_valid_q;
  logic                         wout_last_q;
  logic [NUM_CH*DATA_WIDTH-1:0] wout_q;

  logic wch_ok;
  logic wr_en;
  logic issue;
  logic accept;

  always_comb begin
    wch_ok = ({1'b0, wch} < NUM_CH_W);
    wr_en  = wen && wch_ok && (state_q == IDLE);
    issue  = (state_q == RUN) && (!wout_valid_q || rd_ready);
    accept = wout_valid_q && rd_ready;
  end

  // No reset on the arrays: weights must survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wch][waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      wr_drop_q    <= 1'b0;
      wout_valid_q <= 1'b0;
      wout_last_q  <= 1'b0;
      wout_q       <= '0;
    end else begin
      wr_drop_q <= wen && wch_ok && (state_q != IDLE);

      if (issue) begin
        for (int c = 0; c < NUM_CH; c++) begin
          wout_q[c*DATA_WIDTH +: DATA_WIDTH] <= mem_q[c][cnt_q];
        end
        wout_valid_q <= 1'b1;
        wout_last_q  <= (cnt_q == LAST_ADDR);
      end else if (accept) begin
        wout_valid_q <= 1'b0;
        wout_last_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            if (cnt_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_drop    = wr_drop_q;
  assign busy       = busy_q;
  assign wout       = wout_q;
  assign wout_valid = wout_valid_q;
  assign wout_last  = wout_last_q;

endmodule

// File: tb/tb_weight_memory_bank.sv
// Scoreboard bench for weight_memory_bank: an array model of the weights supplies
// the expected word sets of each run; a negedge monitor checks every accepted word.
module tb_weight_memory_bank;
  localparam int NCH  = 4;
  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int NW   = 10;
  localparam int CW   = 2;
  localparam int NCH3 = 3;
  localparam int NW3  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wen = 1'b0;
  logic [CW-1:0] wch = '0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          start = 1'b0;
  logic          rd_ready = 1'b0;
  logic          wr_drop, busy, wout_valid, wout_last;
  logic [NCH*DW-1:0] wout;

  logic          wen3 = 1'b0;
  logic [CW-1:0] wch3 = '0;
  logic [AW-1:0] waddr3 = '0;
  logic [DW-1:0] wdata3 = '0;
  logic          start3 = 1'b0;
  logic          rd_ready3 = 1'b1;
  logic          wr_drop3, busy3, wout_valid3, wout_last3;
  logic [NCH3*DW-1:0] wout3;

  weight_memory_bank #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WEIGHTS(NW)) u_dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wch(wch), .waddr(waddr), .wdata(wdata),
    .wr_drop(wr_drop), .start(start), .busy(busy), .rd_ready(rd_ready),
    .wout(wout), .wout_valid(wout_valid), .wout_last(wout_last));

  weight_memory_bank #(.NUM_CH(NCH3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WEIGHTS(NW3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .wen(wen3), .wch(wch3), .waddr(waddr3), .wdata(wdata3),
    .wr_drop(wr_drop3), .start(start3), .busy(busy3), .rd_ready(rd_ready3),
    .wout(wout3), .wout_valid(wout_valid3), .wout_last(wout_last3));

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [NCH][2**AW];
  logic [DW-1:0] ref3    [NCH3][2**AW];

  typedef struct packed {
    logic [NCH*DW-1:0] data;
    logic              last;
  } exp_t;
  exp_t exp_q[$];

  int accepted  = 0;
  int rdy_mode  = 0;
  int rdy_phase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream ready: 0 = always, 1 = 1,0,0,1 repeating, 2 = random
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: rd_ready = 1'b1;
      1: begin
        rd_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
        rdy_phase++;
      end
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic              stall_prev = 1'b0;
  logic [NCH*DW-1:0] stall_data = '0;
  logic              busy_fall_chk = 1'b0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      stall_prev    = 1'b0;
      busy_fall_chk = 1'b0;
    end else begin
      if (busy_fall_chk) begin
        check("busy_after_last", 64'(busy), 64'd0);
        busy_fall_chk = 1'b0;
      end
      if (stall_prev) begin
        check("stall_valid", 64'(wout_valid), 64'd1);
        check("stall_hold", wout, stall_data);
      end
      stall_prev = wout_valid && !rd_ready;
      stall_data = wout;
      if (wout_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected no word", wout);
        end else begin
          e = exp_q.pop_front();
          check("wout", wout, e.data);
          check("wout_last", 64'(wout_last), 64'(e.last));
          accepted++;
          if (e.last) begin
            check("busy_at_last", 64'(busy), 64'd1);
            busy_fall_chk = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_run();
    exp_t e;
    for (int k = 0; k < NW; k++) begin
      for (int c = 0; c < NCH; c++) e.data[c*DW +: DW] = ref_mem[c][k];
      e.last = (k == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write_word(input int ch, input int addr, input logic [DW-1:0] d, input bit exp_drop);
    @(posedge clk);
    #1;
    wen = 1'b1; wch = CW'(ch); waddr = AW'(addr); wdata = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
    if (!exp_drop && ch < NCH) ref_mem[ch][addr] = d;
    @(negedge clk);
    check("wr_drop", 64'(wr_drop), 64'(exp_drop));
    @(negedge clk);
    check("wr_drop_pulse", 64'(wr_drop), 64'd0);
  endtask

  // mid: 0 plain, 1 extra start mid-run, 2 write while busy. do_wr: write in the start cycle.
  task automatic run_stream(input int mid, input bit do_wr, input int wc, input int wa, input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    start = 1'b1;
    if (do_wr) begin
      wen = 1'b1; wch = CW'(wc); waddr = AW'(wa); wdata = wd;
      ref_mem[wc][wa] = wd;
    end
    push_run();
    @(posedge clk);
    #1;
    start = 1'b0;
    wen   = 1'b0;
    @(negedge clk);
    check("busy_rise", 64'(busy), 64'd1);
    check("valid_not_yet", 64'(wout_valid), 64'd0);
    @(negedge clk);
    check("first_valid", 64'(wout_valid), 64'd1);
    if (mid == 1) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end else if (mid == 2) begin
      write_word(1, 3, 16'hBEEF, 1'b1);
    end
    wait_done(200);
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic dut3_test();
    int n;
    int k;
    logic [NCH3*DW-1:0] ew;
    for (int c = 0; c < NCH3; c++) begin
      for (int a = 0; a < NW3; a++) begin
        @(posedge clk);
        #1;
        wen3 = 1'b1; wch3 = CW'(c); waddr3 = AW'(a); wdata3 = 16'hA000 | DW'(c << 8) | DW'(a);
        ref3[c][a] = wdata3;
      end
    end
    @(posedge clk);
    #1;
    wen3 = 1'b1; wch3 = 2'd3; waddr3 = 4'd1; wdata3 = 16'hDEAD;
    @(posedge clk);
    #1;
    wen3 = 1'b0;
    @(negedge clk);
    check("wr_drop_badch", 64'(wr_drop3), 64'd0);
    @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    n = 0;
    k = 0;
    while (k < NW3 && n < 50) begin
      @(negedge clk);
      n++;
      if (wout_valid3) begin
        for (int c = 0; c < NCH3; c++) ew[c*DW +: DW] = ref3[c][k];
        check("wout3", 64'(wout3), 64'(ew));
        check("wout_last3", 64'(wout_last3), 64'(k == NW3 - 1));
        k++;
      end
    end
    if (k < NW3) begin
      n_vec++;
      n_err++;
      $display("FAIL dut3_timeout: %0d words seen, expected %0d", k, NW3);
    end
  endtask

  initial begin
    int acc0;
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(wout_valid), 64'd0);
    check("rst_last", 64'(wout_last), 64'd0);
    check("rst_drop", 64'(wr_drop), 64'd0);
    check("rst_wout", wout, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < 2**AW; a++)
        write_word(c, a, DW'((c << 8) | a), 1'b0);

    rdy_mode = 0;
    run_stream(0, 1'b0, 0, 0, '0);
    rdy_mode = 1; rdy_phase = 0;
    run_stream(0, 1'b0, 0, 0, '0);
    rdy_mode = 1; rdy_phase = 0;
    run_stream(2, 1'b0, 0, 0, '0);
    rdy_mode = 0;
    run_stream(0, 1'b0, 0, 0, '0);
    rdy_mode = 2;
    run_stream(1, 1'b0, 0, 0, '0);
    rdy_mode = 0;
    run_stream(0, 1'b1, 2, 0, 16'h5A5A);

    // Reset in the middle of a run
    rdy_mode = 0;
    acc0 = accepted;
    push_run();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (accepted < acc0 + 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_word4", 64'(accepted - acc0), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(wout_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_last", 64'(wout_last), 64'd0);
    check("midrst_wout", wout, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_stream(0, 1'b0, 0, 0, '0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++)
        write_word($urandom_range(0, NCH - 1), $urandom_range(0, NW - 1), DW'($urandom), 1'b0);
      rdy_mode = 2;
      run_stream(0, 1'b0, 0, 0, '0);
    end

    dut3_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
